bird_physics: RTL and testbench

Parametrised bird controller for the LED Flappy Bird game. Keeps the bird's row on a column of `HEIGHT` LEDs and applies a signed velocity model: a key press sets an upward impulse, and each gravity tick moves the bird and pulls the velocity down toward a terminal fall rate. It checks the bird's row against the pipe column at the bird's x-position, tracks game state (idle / flying / dead) and keeps a saturating score. It sits between the key/tick generators and the LED driver and pipe generator.

---
 rtl/bird_pkg.sv | 20 ++
 rtl/bird_physics_if.sv | 36 +++
 rtl/bird_physics_rise_detect.sv | 22 ++
 rtl/bird_physics.sv | 150 +++++++++++++++
 tb/tb_bird_physics.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bird_pkg.sv
// bird_pkg: shared types and helpers for the LED Flappy Bird controller.
//   bird_state_t : game state encoding (IDLE=0, FLY=1, DEAD=2)
//   vel_width()  : signed velocity register width for a given impulse/fall rate
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

  // Room for the larger magnitude, its sign and one extra step below
  // -max_fall, which the decay computation can touch transiently.
  function automatic int vel_width(input int flap_impulse, input int max_fall);
    int m;
    m = (flap_impulse > max_fall) ? flap_impulse : max_fall;
    return $clog2(m) + 2;
  endfunction

endpackage

// File: rtl/bird_physics_if.sv
// bird_physics_if: bundles the game-side inputs and display/status outputs
// of the bird controller.
//   key, tick, pipe_valid, pipe_mask, pipe_passed : stimulus into the bird
//   lights, row, state, dead, score               : registered bird status
//   master : the side driving key/tick/pipe signals (game environment)
//   slave  : the bird controller
interface bird_physics_if #(
  parameter int HEIGHT  = 16,
  parameter int SCORE_W = 8
) ();
  import bird_pkg::*;

  localparam int ROW_W = $clog2(HEIGHT);

  logic                key;
  logic                tick;
  logic                pipe_valid;
  logic [HEIGHT-1:0]   pipe_mask;
  logic                pipe_passed;
  logic [HEIGHT-1:0]   lights;
  logic [ROW_W-1:0]    row;
  bird_state_t         state;
  logic                dead;
  logic [SCORE_W-1:0]  score;

  modport master (
    output key, tick, pipe_valid, pipe_mask, pipe_passed,
    input  lights, row, state, dead, score
  );

  modport slave (
    input  key, tick, pipe_valid, pipe_mask, pipe_passed,
    output lights, row, state, dead, score
  );

endinterface

// File: rtl/bird_physics_rise_detect.sv
// rise_detect: one-cycle pulse on a rising edge of an already-synchronous
// level.
//   clk, reset : clock and synchronous active-high reset
//   level      : input level
//   rise       : high for the cycle in which level goes 0 -> 1
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/bird_physics.sv
// bird_physics: bird row/velocity model, pipe collision, game state and
// saturating score for the LED Flappy Bird game.
//   clk, reset : clock and synchronous active-high reset
//   bus        : bird_physics_if slave
//     in : key (flap button level), tick (physics pulse), pipe_valid,
//          pipe_mask (1 = wall), pipe_passed (score pulse)
//     out: lights (one-hot row), row, state, dead, score -- all registered
module bird_physics
  import bird_pkg::*;
#(
  parameter int HEIGHT       = 16,
  parameter int START_ROW    = 8,
  parameter int FLAP_IMPULSE = 3,
  parameter int MAX_FALL     = 2,
  parameter int SCORE_W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  bird_physics_if.slave bus
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam int VEL_W = vel_width(FLAP_IMPULSE, MAX_FALL);
  // Wide enough for both operands plus carry and sign, so row+vel never wraps.
  localparam int NXT_W = ((ROW_W > VEL_W) ? ROW_W : VEL_W) + 2;

  localparam logic signed [VEL_W-1:0] VEL_FLAP  = VEL_W'(FLAP_IMPULSE);
  localparam logic signed [VEL_W-1:0] VEL_FLOOR = VEL_W'(-MAX_FALL);
  localparam logic signed [VEL_W-1:0] VEL_ONE   = VEL_W'(1);
  localparam logic signed [NXT_W-1:0] NXT_TOP   = NXT_W'(HEIGHT - 1);
  localparam logic signed [NXT_W-1:0] NXT_ZERO  = '0;
  localparam logic [ROW_W-1:0]        ROW_START = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0]        ROW_TOP   = ROW_W'(HEIGHT - 1);
  localparam logic [HEIGHT-1:0]       LIGHT_ONE = HEIGHT'(1);
  localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;

  // Gravity: one row/tick slower, never faster than the terminal fall rate.
  function automatic logic signed [VEL_W-1:0] vel_decay(
    input logic signed [VEL_W-1:0] v
  );
    if (v > VEL_FLOOR) return v - VEL_ONE;
    else               return VEL_FLOOR;
  endfunction

  function automatic logic [SCORE_W-1:0] score_sat_inc(
    input logic [SCORE_W-1:0] s
  );
    if (s == SCORE_MAX) return s;
    else                return s + SCORE_W'(1);
  endfunction

  logic                      flap;
  bird_state_t               state_q, state_n;
  logic [ROW_W-1:0]          row_q, row_n;
  logic [HEIGHT-1:0]         lights_q;
  logic signed [VEL_W-1:0]   vel_q, vel_n, vel_eff;
  logic signed [NXT_W-1:0]   nxt;
  logic [SCORE_W-1:0]        score_q, score_n;
  logic                      dead_q;
  logic                      collide;

  rise_detect u_flap (
    .clk   (clk),
    .reset (reset),
    .level (bus.key),
    .rise  (flap)
  );

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    vel_n   = vel_q;
    score_n = score_q;
    vel_eff = flap ? VEL_FLAP : vel_q;
    nxt     = $signed({{(NXT_W-ROW_W){1'b0}}, row_q}) + NXT_W'(vel_eff);
    collide = bus.pipe_valid & bus.pipe_mask[row_q];

    unique case (state_q)
      IDLE: begin
        row_n = ROW_START;
        vel_n = '0;
        if (flap) begin
          state_n = FLY;
          vel_n   = VEL_FLAP;
          score_n = '0;
        end
      end
      FLY: begin
        // A wall hit freezes the bird where it is, ignoring tick/flap/score.
        if (collide) begin
          state_n = DEAD;
        end else begin
          vel_n = vel_eff;
          if (bus.tick) begin
            if (nxt >= NXT_TOP) begin
              row_n = ROW_TOP;
              vel_n = '0;
            end else if (nxt <= NXT_ZERO) begin
              row_n   = '0;
              vel_n   = '0;
              state_n = DEAD;
            end else begin
              row_n = nxt[ROW_W-1:0];
              vel_n = vel_decay(vel_eff);
            end
          end
          if (bus.pipe_passed) score_n = score_sat_inc(score_q);
        end
      end
      DEAD: begin
        if (flap) begin
          state_n = IDLE;
          row_n   = ROW_START;
          vel_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        row_n   = ROW_START;
        vel_n   = '0;
      end
    endcase
  end

  // lights is decoded from row_n so it shares the register stage with row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= ROW_START;
      lights_q <= LIGHT_ONE << ROW_START;
      vel_q    <= '0;
      score_q  <= '0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      row_q    <= row_n;
      lights_q <= LIGHT_ONE << row_n;
      vel_q    <= vel_n;
      score_q  <= score_n;
      dead_q   <= (state_n == DEAD);
    end
  end

  assign bus.state  = state_q;
  assign bus.row    = row_q;
  assign bus.lights = lights_q;
  assign bus.score  = score_q;
  assign bus.dead   = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: default-parameter instance for physics,
// collision and restart; a SCORE_W=2 instance for score saturation.
module tb_bird_physics;
  import bird_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bird_physics_if #(.HEIGHT(16), .SCORE_W(8)) bif ();
  bird_physics_if #(.HEIGHT(16), .SCORE_W(2)) bif2 ();

  bird_physics #(
    .HEIGHT(16), .START_ROW(8), .FLAP_IMPULSE(3), .MAX_FALL(2), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  bird_physics #(
    .HEIGHT(16), .START_ROW(8), .FLAP_IMPULSE(3), .MAX_FALL(2), .SCORE_W(2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1 ns after the active edge.
  task automatic step(input logic k, input logic t, input logic pv,
                      input logic [15:0] pm, input logic pp);
    bif.key = k; bif.tick = t; bif.pipe_valid = pv;
    bif.pipe_mask = pm; bif.pipe_passed = pp;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic k, input logic pp);
    bif2.key = k; bif2.tick = 1'b0; bif2.pipe_valid = 1'b0;
    bif2.pipe_mask = '0; bif2.pipe_passed = pp;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"},    32'(bif.row), 32'd8);
    chk({tag, "_lights"}, 32'(bif.lights), 32'h0100);
    chk({tag, "_state"},  32'(bif.state), 32'(IDLE));
    chk({tag, "_dead"},   32'(bif.dead), 32'd0);
    chk({tag, "_score"},  32'(bif.score), 32'd0);
  endtask

  initial begin
    int exp_rows [12] = '{11, 13, 14, 14, 13, 11, 9, 7, 5, 3, 1, 0};

    bif.key = 0; bif.tick = 0; bif.pipe_valid = 0; bif.pipe_mask = '0; bif.pipe_passed = 0;
    bif2.key = 0; bif2.tick = 0; bif2.pipe_valid = 0; bif2.pipe_mask = '0; bif2.pipe_passed = 0;

    // Reset state
    reset = 1'b1;
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    reset = 1'b0;
    chk_reset_vals("rst");

    // First flap starts the game; a tick while idle must not move the bird
    step(0, 1, 0, 16'h0, 0);
    chk("idle_tick_row", 32'(bif.row), 32'd8);
    step(1, 0, 0, 16'h0, 0);
    chk("start_state", 32'(bif.state), 32'(FLY));
    chk("start_score", 32'(bif.score), 32'd0);
    chk("start_row",   32'(bif.row), 32'd8);
    step(0, 0, 0, 16'h0, 0);

    // Free-fall trajectory down to the ground
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 16'h0, 0);
      chk($sformatf("traj_row%0d", i),    32'(bif.row), 32'(exp_rows[i]));
      chk($sformatf("traj_lights%0d", i), 32'(bif.lights), 32'h1 << exp_rows[i]);
      chk($sformatf("traj_state%0d", i),  32'(bif.state),
          (i == 11) ? 32'(DEAD) : 32'(FLY));
    end
    chk("ground_dead", 32'(bif.dead), 32'd1);

    // Dead: ticks and pipe_passed ignored
    step(0, 1, 0, 16'h0, 1);
    chk("dead_row",   32'(bif.row), 32'd0);
    chk("dead_score", 32'(bif.score), 32'd0);
    chk("dead_state", 32'(bif.state), 32'(DEAD));

    // Flap from DEAD returns to IDLE at the spawn row
    step(1, 0, 0, 16'h0, 0);
    chk("restart_state",  32'(bif.state), 32'(IDLE));
    chk("restart_row",    32'(bif.row), 32'd8);
    chk("restart_lights", 32'(bif.lights), 32'h0100);
    chk("restart_dead",   32'(bif.dead), 32'd0);
    step(0, 0, 0, 16'h0, 0);

    // Key held 20 cycles with ticks: only one impulse, bird falls and dies
    step(1, 1, 0, 16'h0, 0);
    chk("hold_start", 32'(bif.state), 32'(FLY));
    for (int i = 1; i < 20; i++) begin
      step(1, 1, 0, 16'h0, 0);
      if (i == 3) chk("hold_row3", 32'(bif.row), 32'd14);
      if (i == 6) chk("hold_row6", 32'(bif.row), 32'd11);
    end
    chk("hold_state", 32'(bif.state), 32'(DEAD));
    chk("hold_row",   32'(bif.row), 32'd0);
    step(0, 0, 0, 16'h0, 0);

    // Ceiling clamp
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    chk("ceil_fly", 32'(bif.state), 32'(FLY));
    step(0, 1, 0, 16'h0, 0);
    chk("ceil_row11", 32'(bif.row), 32'd11);
    step(0, 1, 0, 16'h0, 0);
    chk("ceil_row13", 32'(bif.row), 32'd13);
    step(1, 1, 0, 16'h0, 0);
    chk("ceil_row",    32'(bif.row), 32'd15);
    chk("ceil_lights", 32'(bif.lights), 32'h8000);
    chk("ceil_state",  32'(bif.state), 32'(FLY));
    step(0, 0, 0, 16'h0, 0);
    step(1, 1, 0, 16'h0, 0);
    chk("ceil_row2", 32'(bif.row), 32'd15);
    step(0, 1, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    chk("ceil_row_vel0", 32'(bif.row), 32'd15);
    chk("ceil_state2",   32'(bif.state), 32'(FLY));

    // Reset from FLY
    reset = 1'b1;
    step(0, 0, 0, 16'h0, 0);
    reset = 1'b0;
    chk_reset_vals("rst_ceil");

    // Collision and scoring
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 1, 16'hFC3F, 1);
    chk("gap_state", 32'(bif.state), 32'(FLY));
    chk("gap_score", 32'(bif.score), 32'd1);
    step(0, 1, 0, 16'h0, 0);
    chk("pre_hit_row", 32'(bif.row), 32'd11);
    step(0, 1, 1, 16'hFC3F, 1);
    chk("hit_state",  32'(bif.state), 32'(DEAD));
    chk("hit_dead",   32'(bif.dead), 32'd1);
    chk("hit_row",    32'(bif.row), 32'd11);
    chk("hit_lights", 32'(bif.lights), 32'h0800);
    chk("hit_score",  32'(bif.score), 32'd1);
    step(0, 1, 0, 16'h0, 1);
    chk("hit_frozen_row",   32'(bif.row), 32'd11);
    chk("hit_frozen_score", 32'(bif.score), 32'd1);
    step(1, 0, 0, 16'h0, 0);
    chk("hit_idle",       32'(bif.state), 32'(IDLE));
    chk("hit_idle_row",   32'(bif.row), 32'd8);
    chk("hit_idle_score", 32'(bif.score), 32'd1);
    step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    chk("newgame_state", 32'(bif.state), 32'(FLY));
    chk("newgame_score", 32'(bif.score), 32'd0);
    step(0, 0, 0, 16'h0, 1);
    chk("newgame_score1", 32'(bif.score), 32'd1);
    step(0, 1, 0, 16'h0, 0);
    chk("midfly_row", 32'(bif.row), 32'd11);

    // Reset mid-flight clears everything, including the score
    reset = 1'b1;
    step(0, 1, 0, 16'h0, 1);
    reset = 1'b0;
    chk_reset_vals("rst_mid");

    // Score saturation with a 2-bit counter
    step2(1, 0);
    chk("sat_fly", 32'(bif2.state), 32'(FLY));
    for (int i = 0; i < 5; i++) begin
      step2(0, 1);
      chk($sformatf("sat_score%0d", i), 32'(bif2.score), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
